// File: rtl/hazard_unit_pkg.sv
// Shared pipeline constants for the hazard unit: FSM encoding, register zero, stall counter width.
package hazard_unit_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         STALL_W  = 16;

endpackage

// File: rtl/hazard_match.sv
// Single source/destination dependency comparator; register zero never creates a dependency.
module hazard_match
    import hazard_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic       uses,
    input  logic [4:0] dst,
    output logic       match
);

    assign match = uses && (dst != REG_ZERO) && (src == dst);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stalls on load-use and branch/jr operand hazards, flushes IF/ID on taken redirects.
//
// state | meaning
// RUN   | normal issue; hazards stall combinationally in the same cycle
// HOLD  | second stall cycle of a branch/jr waiting on a load in EX
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [4:0]           IFIDRs,
    input  logic [4:0]           IFIDRt,
    input  logic                 IFIDUsesRt,
    input  logic                 IDBranch,
    input  logic                 IDJr,
    input  logic                 IDTaken,
    input  logic [1:0]           IDEXMemRead,
    input  logic                 IDEXRegWrite,
    input  logic [4:0]           IDEXWriteReg,
    input  logic [1:0]           EXMEMMemRead,
    input  logic [4:0]           EXMEMWriteReg,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 controlMuxSignal,
    output logic                 IFIDFlush,
    output logic [STALL_W-1:0]   StallCount
);

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    hz_state_t          state_q, state_d;
    logic [STALL_W-1:0] stall_count_q, stall_count_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic ex_dep, mem_dep, ex_load, mem_load, br_or_jr;
    logic load_use, br_alu, br_load, br_mem, any_hazard;
    logic stall, flush;

    hazard_match u_rs_ex  (.src(IFIDRs), .uses(1'b1),       .dst(IDEXWriteReg),  .match(rs_ex));
    hazard_match u_rt_ex  (.src(IFIDRt), .uses(IFIDUsesRt), .dst(IDEXWriteReg),  .match(rt_ex));
    hazard_match u_rs_mem (.src(IFIDRs), .uses(1'b1),       .dst(EXMEMWriteReg), .match(rs_mem));
    hazard_match u_rt_mem (.src(IFIDRt), .uses(IFIDUsesRt), .dst(EXMEMWriteReg), .match(rt_mem));

    always_comb begin
        ex_dep     = rs_ex | rt_ex;
        mem_dep    = rs_mem | rt_mem;
        ex_load    = (IDEXMemRead != 2'b00);
        mem_load   = (EXMEMMemRead != 2'b00);
        br_or_jr   = IDBranch | IDJr;
        load_use   = ex_load & ex_dep;
        br_alu     = br_or_jr & IDEXRegWrite & ~ex_load & ex_dep;
        br_load    = br_or_jr & ex_load & ex_dep;
        br_mem     = br_or_jr & mem_load & mem_dep;
        any_hazard = load_use | br_alu | br_load | br_mem;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (any_hazard) begin
                    stall = 1'b1;
                    if (br_load) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    flush = IDTaken;
                end
            end
            ST_HOLD: begin
                stall   = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Reset forces the free-running outputs immediately, even with hazardous inputs present.
    always_comb begin
        PCWrite          = ~(Rst & stall);
        IFIDWrite        = ~(Rst & stall);
        controlMuxSignal = ~(Rst & stall);
        IFIDFlush        = Rst & flush;
    end

    assign StallCount = stall_count_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= ST_RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a stall-budget model.
module tb_hazard_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  IFIDRs, IFIDRt, IDEXWriteReg, EXMEMWriteReg;
    logic        IFIDUsesRt, IDBranch, IDJr, IDTaken, IDEXRegWrite;
    logic [1:0]  IDEXMemRead, EXMEMMemRead;
    logic        PCWrite, IFIDWrite, controlMuxSignal, IFIDFlush;
    logic [15:0] StallCount;

    int n_cmp = 0;
    int n_bad = 0;
    int m_hold = 0;
    int m_cnt  = 0;

    hazard_unit dut (
        .Clk(Clk), .Rst(Rst),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRt(IFIDUsesRt),
        .IDBranch(IDBranch), .IDJr(IDJr), .IDTaken(IDTaken),
        .IDEXMemRead(IDEXMemRead), .IDEXRegWrite(IDEXRegWrite), .IDEXWriteReg(IDEXWriteReg),
        .EXMEMMemRead(EXMEMMemRead), .EXMEMWriteReg(EXMEMWriteReg),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .controlMuxSignal(controlMuxSignal),
        .IFIDFlush(IFIDFlush), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit dep(input logic [4:0] src, input bit used, input logic [4:0] dst);
        return used && dst != 0 && src == dst;
    endfunction

    // Number of stall cycles the current ID instruction still needs, straight from the hazard rules.
    function automatic int stalls_needed();
        bit ex_d, mem_d, br;
        int n;
        ex_d  = dep(IFIDRs, 1'b1, IDEXWriteReg)  || dep(IFIDRt, IFIDUsesRt, IDEXWriteReg);
        mem_d = dep(IFIDRs, 1'b1, EXMEMWriteReg) || dep(IFIDRt, IFIDUsesRt, EXMEMWriteReg);
        br    = IDBranch || IDJr;
        n = 0;
        if (IDEXMemRead != 0 && ex_d) n = 1;
        if (br && IDEXRegWrite && IDEXMemRead == 0 && ex_d) n = 1;
        if (br && EXMEMMemRead != 0 && mem_d && n < 1) n = 1;
        if (br && IDEXMemRead != 0 && ex_d) n = 2;
        return n;
    endfunction

    task automatic clear_inputs();
        IFIDRs = 0; IFIDRt = 0; IFIDUsesRt = 0; IDBranch = 0; IDJr = 0; IDTaken = 0;
        IDEXMemRead = 0; IDEXRegWrite = 0; IDEXWriteReg = 0; EXMEMMemRead = 0; EXMEMWriteReg = 0;
    endtask

    // Called just after a negedge with inputs applied; checks, crosses the posedge, returns at the next negedge.
    task automatic cycle_check(input string tag);
        bit e_stall, e_flush;
        int need;
        #1;
        need    = 0;
        e_stall = 0;
        e_flush = 0;
        if (Rst) begin
            if (m_hold > 0) e_stall = 1;
            else begin
                need = stalls_needed();
                if (need > 0) e_stall = 1;
                else e_flush = IDTaken;
            end
        end
        check({tag, ".pc"},    {31'd0, PCWrite},          {31'd0, ~e_stall});
        check({tag, ".ifid"},  {31'd0, IFIDWrite},        {31'd0, ~e_stall});
        check({tag, ".ctl"},   {31'd0, controlMuxSignal}, {31'd0, ~e_stall});
        check({tag, ".flush"}, {31'd0, IFIDFlush},        {31'd0, e_flush});
        check({tag, ".cnt"},   {16'd0, StallCount},       m_cnt);
        @(posedge Clk);
        if (Rst) begin
            if (e_stall && m_cnt < 65535) m_cnt++;
            if (m_hold > 0) m_hold--;
            else if (need > 0) m_hold = need - 1;
        end else begin
            m_cnt  = 0;
            m_hold = 0;
        end
        @(negedge Clk);
    endtask

    initial begin
        clear_inputs();
        Rst = 1'b0;
        // Hazardous inputs during reset must not disturb the reset output values.
        IDEXMemRead = 2'b01; IDEXWriteReg = 5'd8; IFIDRs = 5'd8; IDTaken = 1'b1;
        #3;
        check("reset.pc",    {31'd0, PCWrite},          32'd1);
        check("reset.ctl",   {31'd0, controlMuxSignal}, 32'd1);
        check("reset.flush", {31'd0, IFIDFlush},        32'd0);
        check("reset.cnt",   {16'd0, StallCount},       32'd0);
        @(negedge Clk);
        clear_inputs();
        Rst = 1'b1;
        cycle_check("idle");

        // Load-use on Rs: one stall.
        IDEXMemRead = 2'b01; IDEXWriteReg = 5'd8; IFIDRs = 5'd8;
        cycle_check("lu.stall");
        clear_inputs();
        cycle_check("lu.after");
        check("lu.cnt", {16'd0, StallCount}, 32'd1);

        // Register zero never matches.
        IDEXMemRead = 2'b01; IDEXWriteReg = 5'd0; IFIDRs = 5'd0;
        cycle_check("zero");

        // Branch on load through Rt: RUN stall, HOLD stall, then the deferred flush.
        clear_inputs();
        IDBranch = 1; IDEXMemRead = 2'b01; IDEXWriteReg = 5'd5; IFIDRt = 5'd5; IFIDUsesRt = 1; IDTaken = 1;
        cycle_check("brld.run");
        cycle_check("brld.hold");
        IDEXMemRead = 2'b00; IDEXWriteReg = 5'd0;
        cycle_check("brld.flush");
        clear_inputs();
        cycle_check("brld.after");
        check("brld.cnt", {16'd0, StallCount}, 32'd3);

        // Jr ALU hazard on Rs; Rt match ignored when not used.
        IDJr = 1; IDEXRegWrite = 1; IDEXWriteReg = 5'd31; IFIDRs = 5'd31;
        cycle_check("jr.stall");
        IFIDRs = 5'd1; IFIDRt = 5'd31; IFIDUsesRt = 0;
        cycle_check("jr.rt_ignored");

        // Reset asserted mid-HOLD abandons the remaining stall.
        clear_inputs();
        IDBranch = 1; IDEXMemRead = 2'b10; IDEXWriteReg = 5'd7; IFIDRs = 5'd7;
        cycle_check("rsthold.run");
        #2;
        Rst = 1'b0;
        #1;
        check("rsthold.pc",    {31'd0, PCWrite},          32'd1);
        check("rsthold.ifid",  {31'd0, IFIDWrite},        32'd1);
        check("rsthold.ctl",   {31'd0, controlMuxSignal}, 32'd1);
        check("rsthold.flush", {31'd0, IFIDFlush},        32'd0);
        check("rsthold.cnt",   {16'd0, StallCount},       32'd0);
        m_cnt = 0; m_hold = 0;
        @(negedge Clk);
        clear_inputs();
        Rst = 1'b1;
        IDTaken = 1;
        cycle_check("rsthold.resume");
        clear_inputs();

        // Randomized traffic with small register numbers so dependencies are frequent.
        for (int i = 0; i < 400; i++) begin
            IFIDRs        = 5'($urandom_range(0, 3));
            IFIDRt        = 5'($urandom_range(0, 3));
            IFIDUsesRt    = 1'($urandom);
            IDBranch      = ($urandom_range(0, 3) == 0);
            IDJr          = ($urandom_range(0, 5) == 0);
            IDTaken       = 1'($urandom);
            IDEXMemRead   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            IDEXRegWrite  = 1'($urandom);
            IDEXWriteReg  = 5'($urandom_range(0, 3));
            EXMEMMemRead  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            EXMEMWriteReg = 5'($urandom_range(0, 3));
            cycle_check("rand");
        end

        // Saturation: drive the counter to 0xFFFE with a held load-use, then three more stalls.
        clear_inputs();
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        Rst = 1'b1;
        m_cnt = 0; m_hold = 0;
        IDEXMemRead = 2'b01; IDEXWriteReg = 5'd9; IFIDRs = 5'd9;
        for (int i = 0; i < 65534; i++) @(posedge Clk);
        m_cnt = 65534;
        @(negedge Clk);
        cycle_check("sat.1");
        cycle_check("sat.2");
        cycle_check("sat.3");
        check("sat.final", {16'd0, StallCount}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
